// File: rtl/scl_gen_prog.sv
// rtl/scl_gen_prog.sv - SDR SCL generator, fixed push-pull and programmable open-drain phase lengths
// Optional target clock stretching in the high phase is enabled by defining SCL_GEN_STRETCH_EN.
module scl_gen_prog #(
  parameter int CNT_W       = 7,
  parameter int PP_LOW_CNT  = 2,
  parameter int PP_HIGH_CNT = 2,
  parameter int OD_RST_LOW  = 63,
  parameter int OD_RST_HIGH = 62
) (
  input  logic             i_sdr_ctrl_clk,
  input  logic             i_sdr_ctrl_rst,
  input  logic             i_sdr_scl_gen_pp_od,
  input  logic             i_od_cfg_wr,
  input  logic [CNT_W-1:0] i_od_low_cnt,
  input  logic [CNT_W-1:0] i_od_high_cnt,
  input  logic             i_scl_gen_stall,
  input  logic             i_sdr_ctrl_scl_idle,
  input  logic             i_timer_cas,
`ifdef SCL_GEN_STRETCH_EN
  input  logic             i_scl_sense,
`endif
  output logic             o_scl,
  output logic             o_scl_pos_edge,
  output logic             o_scl_neg_edge,
  output logic             o_scl_busy
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PP_LOW  = CNT_W'(PP_LOW_CNT);
  localparam logic [CNT_W-1:0] PP_HIGH = CNT_W'(PP_HIGH_CNT);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] od_low;
  logic [CNT_W-1:0] od_high;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] high_len;
  logic             last_cnt;
  logic             hold_high;

  // Phase lengths follow the mode present in the load cycle; a zero count behaves as one.
  always_comb begin
    low_len  = i_sdr_scl_gen_pp_od ? PP_LOW  : od_low;
    high_len = i_sdr_scl_gen_pp_od ? PP_HIGH : od_high;
    if (low_len == '0)  low_len  = ONE;
    if (high_len == '0) high_len = ONE;
  end

  assign last_cnt = (cnt <= ONE);

`ifdef SCL_GEN_STRETCH_EN
  assign hold_high = ~i_scl_sense;
`else
  assign hold_high = 1'b0;
`endif

  always_ff @(posedge i_sdr_ctrl_clk or posedge i_sdr_ctrl_rst) begin
    if (i_sdr_ctrl_rst) begin
      od_low  <= CNT_W'(OD_RST_LOW);
      od_high <= CNT_W'(OD_RST_HIGH);
    end else if (i_od_cfg_wr) begin
      od_low  <= i_od_low_cnt;
      od_high <= i_od_high_cnt;
    end
  end

  always_ff @(posedge i_sdr_ctrl_clk or posedge i_sdr_ctrl_rst) begin
    if (i_sdr_ctrl_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      o_scl          <= 1'b1;
      o_scl_pos_edge <= 1'b0;
      o_scl_neg_edge <= 1'b0;
      o_scl_busy     <= 1'b0;
    end else begin
      o_scl_pos_edge <= 1'b0;
      o_scl_neg_edge <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_sdr_ctrl_scl_idle || i_timer_cas) begin
            state          <= LOW;
            cnt            <= low_len;
            o_scl          <= 1'b0;
            o_scl_neg_edge <= 1'b1;
            o_scl_busy     <= 1'b1;
          end
        end
        LOW: begin
          if (!i_scl_gen_stall) begin
            if (last_cnt) begin
              state          <= HIGH;
              cnt            <= high_len;
              o_scl          <= 1'b1;
              o_scl_pos_edge <= 1'b1;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        HIGH: begin
          // A start request cuts the high phase short regardless of count, idle or stretch.
          if (i_timer_cas || (!hold_high && last_cnt && !i_sdr_ctrl_scl_idle)) begin
            state          <= LOW;
            cnt            <= low_len;
            o_scl          <= 1'b0;
            o_scl_neg_edge <= 1'b1;
          end else if (!hold_high) begin
            if (last_cnt) begin
              state      <= IDLE;
              cnt        <= '0;
              o_scl_busy <= 1'b0;
            end else begin
              cnt <= cnt - ONE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          o_scl      <= 1'b1;
          o_scl_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
